// File: rtl/cluster_cfg_dispatcher.sv
// rtl/cluster_cfg_dispatcher.sv - vsetvl/vsetvli/vsetivli decode, architectural vl/vtype, per-cluster split and in-order config queue
// vtype is packed {vill, vma, vta, vsew[2:0], vlmul[2:0]}; cluster c of cl_vl sits at [c*ClVlW +: ClVlW].
module cluster_cfg_dispatcher #(
  parameter int unsigned NrClusters   = 4,
  parameter int unsigned ClusterVLENB = 64,
  parameter int unsigned CfgDepth     = 4,
  localparam int unsigned MaxVl = ClusterVLENB * NrClusters * 8,
  localparam int unsigned VlW   = $clog2(MaxVl) + 1,
  localparam int unsigned ClVlW = VlW - $clog2(NrClusters)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [31:0]                 insn_i,
  input  logic [63:0]                 rs1_i,
  input  logic [63:0]                 rs2_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic [63:0]                 resp_vl_o,
  output logic                        cfg_valid_o,
  input  logic                        cfg_ready_i,
  output logic [VlW-1:0]              cfg_vl_o,
  output logic [8:0]                  cfg_vtype_o,
  output logic [NrClusters*ClVlW-1:0] cfg_cl_vl_o,
  output logic [VlW-1:0]              vl_o,
  output logic [8:0]                  vtype_o
);
  localparam int unsigned LogN = $clog2(NrClusters);
  localparam int unsigned PtrW = $clog2(CfgDepth);
  localparam int unsigned CntW = $clog2(CfgDepth + 1);
  localparam int unsigned ClW  = NrClusters * ClVlW;
  localparam int unsigned EntW = VlW + 9 + ClW;
  localparam logic [VlW-1:0] VlenB    = VlW'(ClusterVLENB * NrClusters);
  localparam logic [8:0]     VtypeIll = 9'h100;

  typedef enum logic {IDLE, RESP} state_e;

  state_e          state_q, state_d;
  logic [VlW-1:0]  vl_q, vl_d;
  logic [VlW-1:0]  resp_vl_q, resp_vl_d;
  logic [8:0]      vtype_q, vtype_d;
  logic [EntW-1:0] mem_q [CfgDepth];
  logic [EntW-1:0] mem_d [CfgDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic              is_vsetvli, is_vsetivli, is_vsetvl, is_cfg;
  logic [63:0]       vtype_raw;
  logic [2:0]        vsew, vlmul;
  logic signed [4:0] lmul_s, sew_s;
  logic              vtype_bad, new_ill;
  logic [4:0]        rd_idx, rs1_idx;
  logic [VlW-1:0]    vlmax, new_vl, rem;
  logic [8:0]        new_vtype;
  logic [ClW-1:0]    new_cl;
  logic              push, pop, accept;

  always_comb begin
    is_vsetvli  = ~insn_i[31];
    is_vsetivli = insn_i[31:30] == 2'b11;
    is_vsetvl   = insn_i[31:25] == 7'b1000000;
    is_cfg      = (insn_i[6:0] == 7'h57) && (insn_i[14:12] == 3'b111) &&
                  (is_vsetvli || is_vsetivli || is_vsetvl);
    rd_idx      = insn_i[11:7];
    rs1_idx     = insn_i[19:15];

    if (is_vsetvli) begin
      vtype_raw = {53'b0, insn_i[30:20]};
    end else if (is_vsetivli) begin
      vtype_raw = {54'b0, insn_i[29:20]};
    end else begin
      vtype_raw = rs2_i;
    end
    vsew   = vtype_raw[5:3];
    vlmul  = vtype_raw[2:0];
    lmul_s = {{2{vlmul[2]}}, vlmul};
    sew_s  = {2'b00, vsew};
    vtype_bad = vtype_raw[63] || (|vtype_raw[62:8]) || (vsew > 3'd3) ||
                (vlmul == 3'd4) || ((lmul_s + 5'sd3) < sew_s);

    // Fractional LMUL encodings 5/6/7 divide by 8/4/2, i.e. shift right by (8 - vlmul).
    vlmax = VlenB >> vsew;
    if (vlmul[2]) begin
      vlmax = vlmax >> (3'd0 - vlmul);
    end else begin
      vlmax = vlmax << vlmul[1:0];
    end

    new_ill = vtype_bad;
    if (is_vsetivli) begin
      new_vl = (VlW'(rs1_idx) < vlmax) ? VlW'(rs1_idx) : vlmax;
    end else if (rs1_idx == 5'd0 && rd_idx == 5'd0) begin
      new_vl = vl_q;
      if (vl_q > vlmax) new_ill = 1'b1;
    end else if (rs1_idx == 5'd0) begin
      new_vl = vlmax;
    end else begin
      new_vl = (rs1_i <= 64'(vlmax)) ? VlW'(rs1_i) : vlmax;
    end

    if (new_ill) begin
      new_vl    = '0;
      new_vtype = VtypeIll;
    end else begin
      new_vtype = {1'b0, vtype_raw[7:0]};
    end

    rem    = new_vl & VlW'(NrClusters - 1);
    new_cl = '0;
    for (int c = 0; c < NrClusters; c++) begin
      new_cl[c*ClVlW +: ClVlW] = ClVlW'(new_vl >> LogN) + ClVlW'(VlW'(c) < rem);
    end
  end

  assign req_ready_o = (state_q == IDLE) && (count_q != CntW'(CfgDepth));
  assign accept      = req_valid_i && req_ready_o;
  assign push        = accept && is_cfg;
  assign pop         = cfg_valid_o && cfg_ready_i;

  always_comb begin
    state_d   = state_q;
    vl_d      = vl_q;
    vtype_d   = vtype_q;
    resp_vl_d = resp_vl_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (state_q == RESP && resp_ready_i) state_d = IDLE;
    if (push) begin
      state_d         = RESP;
      vl_d            = new_vl;
      vtype_d         = new_vtype;
      resp_vl_d       = new_vl;
      mem_d[wr_ptr_q] = {new_vl, new_vtype, new_cl};
      wr_ptr_d        = (wr_ptr_q == PtrW'(CfgDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(CfgDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      vl_q      <= '0;
      vtype_q   <= VtypeIll;
      resp_vl_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < CfgDepth; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      vl_q      <= vl_d;
      vtype_q   <= vtype_d;
      resp_vl_q <= resp_vl_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  assign resp_valid_o = (state_q == RESP);
  assign resp_vl_o    = 64'(resp_vl_q);
  assign vl_o         = vl_q;
  assign vtype_o      = vtype_q;
  assign cfg_valid_o  = (count_q != '0);
  assign {cfg_vl_o, cfg_vtype_o, cfg_cl_vl_o} = cfg_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_cluster_cfg_dispatcher.sv
// tb/tb_cluster_cfg_dispatcher.sv - directed scoreboard bench for cluster_cfg_dispatcher (N=4, 64 B/cluster)
module tb_cluster_cfg_dispatcher;
  localparam int VlW   = 12;
  localparam int ClVlW = 10;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b1;
  logic              req_valid_i, req_ready_o;
  logic [31:0]       insn_i;
  logic [63:0]       rs1_i, rs2_i;
  logic              resp_valid_o, resp_ready_i;
  logic [63:0]       resp_vl_o;
  logic              cfg_valid_o, cfg_ready_i;
  logic [VlW-1:0]    cfg_vl_o, vl_o;
  logic [8:0]        cfg_vtype_o, vtype_o;
  logic [4*ClVlW-1:0] cfg_cl_vl_o;

  int n_tests;
  int n_fail;
  logic [63:0] resp_q [$];
  logic [VlW+9+4*ClVlW-1:0] cfg_q [$];

  cluster_cfg_dispatcher #(.NrClusters(4), .ClusterVLENB(64), .CfgDepth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .insn_i(insn_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_vl_o(resp_vl_o),
    .cfg_valid_o(cfg_valid_o), .cfg_ready_i(cfg_ready_i), .cfg_vl_o(cfg_vl_o),
    .cfg_vtype_o(cfg_vtype_o), .cfg_cl_vl_o(cfg_cl_vl_o),
    .vl_o(vl_o), .vtype_o(vtype_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] cl4(input int a0, input int a1, input int a2, input int a3);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] zimm);
    return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm, input logic [9:0] zimm);
    return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1);
    return {7'b1000000, 5'd2, rs1, 3'b111, rd, 7'h57};
  endfunction

  // Called on a falling edge; offers one instruction and checks the T+1 results.
  task automatic issue(input logic [31:0] insn, input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic cfg, input logic [VlW-1:0] evl, input logic [8:0] evt,
                       input logic [39:0] ecl);
    int guard;
    guard = 0;
    while (!req_ready_o && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    chk("req_ready_wait", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    insn_i = insn;
    rs1_i = rs1;
    rs2_i = rs2;
    if (cfg) begin
      resp_q.push_back(64'(evl));
      cfg_q.push_back({evl, evt, ecl});
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    insn_i = '0;
    rs1_i = '0;
    rs2_i = '0;
    if (cfg) begin
      chk("resp_valid", 64'(resp_valid_o), 64'd1);
      chk("resp_vl", resp_vl_o, resp_q.pop_front());
      chk("vl_o", 64'(vl_o), 64'(evl));
      chk("vtype_o", 64'(vtype_o), 64'(evt));
    end else begin
      chk("drop_no_resp", 64'(resp_valid_o), 64'd0);
    end
  endtask

  task automatic drain_one();
    logic [VlW+9+4*ClVlW-1:0] e;
    int guard;
    guard = 0;
    while (!cfg_valid_o && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    e = cfg_q.pop_front();
    chk("cfg_valid", 64'(cfg_valid_o), 64'd1);
    chk("cfg_vl", 64'(cfg_vl_o), 64'(e[60:49]));
    chk("cfg_vtype", 64'(cfg_vtype_o), 64'(e[48:40]));
    chk("cfg_cl_vl", 64'(cfg_cl_vl_o), 64'(e[39:0]));
    cfg_ready_i = 1'b1;
    @(negedge clk_i);
    cfg_ready_i = 1'b0;
  endtask

  task automatic drain_all();
    while (cfg_q.size() > 0) drain_one();
    chk("cfg_empty", 64'(cfg_valid_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    req_valid_i = 1'b0;
    insn_i = '0;
    rs1_i = '0;
    rs2_i = '0;
    resp_ready_i = 1'b1;
    cfg_ready_i = 1'b0;

    #1 rst_ni = 1'b0;
    #2;
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_cfg_valid", 64'(cfg_valid_o), 64'd0);
    chk("rst_vl", 64'(vl_o), 64'd0);
    chk("rst_vtype", 64'(vtype_o), 64'h100);
    chk("rst_resp_vl", resp_vl_o, 64'd0);
    chk("rst_cfg_vl", 64'(cfg_vl_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);

    // e32 m1: vlmax 64
    issue(enc_vsetvli(5'd5, 5'd1, 11'h010), 64'd100, 64'd0, 1'b1, 12'd64, 9'h010, cl4(16, 16, 16, 16));
    drain_all();
    issue(enc_vsetvli(5'd5, 5'd1, 11'h010), 64'd10, 64'd0, 1'b1, 12'd10, 9'h010, cl4(3, 3, 2, 2));
    drain_all();
    issue(enc_vsetvli(5'd5, 5'd1, 11'h010), 64'h100_0000_0000, 64'd0, 1'b1, 12'd64, 9'h010, cl4(16, 16, 16, 16));
    drain_all();

    // vsetivli: e8 mf8 and e64 m1 give vlmax 32; e64 mf2 violates SEW <= LMUL*64
    issue(enc_vsetivli(5'd5, 5'd31, 10'h005), 64'd0, 64'd0, 1'b1, 12'd31, 9'h005, cl4(8, 8, 8, 7));
    drain_all();
    issue(enc_vsetivli(5'd5, 5'd31, 10'h018), 64'd0, 64'd0, 1'b1, 12'd31, 9'h018, cl4(8, 8, 8, 7));
    drain_all();
    issue(enc_vsetivli(5'd5, 5'd31, 10'h01F), 64'd0, 64'd0, 1'b1, 12'd0, 9'h100, cl4(0, 0, 0, 0));
    drain_all();

    // vsetvl with illegal rs2
    issue(enc_vsetvl(5'd5, 5'd1), 64'd10, 64'h1D, 1'b1, 12'd0, 9'h100, cl4(0, 0, 0, 0));
    drain_all();
    issue(enc_vsetvl(5'd5, 5'd1), 64'd10, 64'h110, 1'b1, 12'd0, 9'h100, cl4(0, 0, 0, 0));
    drain_all();

    // keep-vl forms
    issue(enc_vsetvli(5'd5, 5'd1, 11'h010), 64'd10, 64'd0, 1'b1, 12'd10, 9'h010, cl4(3, 3, 2, 2));
    issue(enc_vsetvli(5'd0, 5'd0, 11'h008), 64'd999, 64'd0, 1'b1, 12'd10, 9'h008, cl4(3, 3, 2, 2));
    drain_all();
    issue(enc_vsetvli(5'd5, 5'd0, 11'h003), 64'd0, 64'd0, 1'b1, 12'd2048, 9'h003, cl4(512, 512, 512, 512));
    issue(enc_vsetvli(5'd0, 5'd0, 11'h017), 64'd0, 64'd0, 1'b1, 12'd0, 9'h100, cl4(0, 0, 0, 0));
    drain_all();

    // dropped instructions, back to back
    for (int i = 0; i < 3; i++) begin
      chk("drop_ready", 64'(req_ready_o), 64'd1);
      issue((i == 1) ? 32'h8200_7057 : 32'h0000_0013, 64'd5, 64'd0, 1'b0, '0, '0, '0);
    end
    chk("drop_vl_kept", 64'(vl_o), 64'd0);
    chk("drop_no_cfg", 64'(cfg_valid_o), 64'd0);

    // backpressure: fill the queue, then drain in order
    for (int k = 1; k <= 4; k++) begin
      issue(enc_vsetvli(5'd5, 5'd1, 11'h010), 64'(k), 64'd0, 1'b1, 12'(k), 9'h010,
            cl4((k + 3) / 4, (k + 2) / 4, (k + 1) / 4, k / 4));
    end
    @(negedge clk_i);
    chk("full_block", 64'(req_ready_o), 64'd0);
    @(negedge clk_i);
    chk("full_still_block", 64'(req_ready_o), 64'd0);
    drain_one();
    chk("reaccept", 64'(req_ready_o), 64'd1);
    issue(enc_vsetvli(5'd5, 5'd1, 11'h010), 64'd5, 64'd0, 1'b1, 12'd5, 9'h010, cl4(2, 1, 1, 1));
    drain_all();

    // reset while holding a response with 2 entries queued
    issue(enc_vsetivli(5'd5, 5'd9, 10'h010), 64'd0, 64'd0, 1'b1, 12'd9, 9'h010, cl4(3, 2, 2, 2));
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    issue(enc_vsetivli(5'd5, 5'd12, 10'h010), 64'd0, 64'd0, 1'b1, 12'd12, 9'h010, cl4(3, 3, 3, 3));
    @(negedge clk_i);
    chk("resp_hold_valid", 64'(resp_valid_o), 64'd1);
    chk("resp_hold_vl", resp_vl_o, 64'd12);
    chk("resp_hold_ready", 64'(req_ready_o), 64'd0);
    chk("two_queued", 64'(cfg_valid_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("mid_rst_cfg_valid", 64'(cfg_valid_o), 64'd0);
    chk("mid_rst_vtype", 64'(vtype_o), 64'h100);
    resp_q.delete();
    cfg_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", 64'(req_ready_o), 64'd1);
    chk("post_rst_vl", 64'(vl_o), 64'd0);
    issue(enc_vsetivli(5'd5, 5'd7, 10'h000), 64'd0, 64'd0, 1'b1, 12'd7, 9'h000, cl4(2, 2, 2, 1));
    drain_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
